fetch_queue: RTL and testbench

FETCH_QUEUE -- requirements
Module: fetch_queue

---
 rtl/fetch_queue_if.sv | 33 +++
 rtl/fetch_queue.sv | 95 +++++++++
 tb/tb_fetch_queue.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/fetch_queue_if.sv
// Fetch-side bundle: redirect request, instruction-memory port and the decode handshake.
// master = fetch_queue, slave = surrounding pipeline / memory.
interface fetch_queue_if #(
   parameter int WORD      = 64,
   parameter int INSTR_LEN = 32,
   parameter int DEPTH     = 4
);
   localparam int OCC_W = $clog2(DEPTH + 1);

   logic [WORD-1:0]      branch_target;
   logic                 pc_src;
   logic                 imem_req;
   logic [WORD-1:0]      imem_addr;
   logic [INSTR_LEN-1:0] imem_rdata;
   // Decode handshake: the head entry {cur_pc_if, instr_if} moves when
   // instr_valid && instr_ready are both high at a rising edge. instr_valid
   // does not depend on instr_ready; payload is meaningless while instr_valid=0.
   logic                 instr_valid;
   logic                 instr_ready;
   logic [INSTR_LEN-1:0] instr_if;
   logic [WORD-1:0]      cur_pc_if;
   logic [OCC_W-1:0]     occupancy;

   modport master (
      input  branch_target, pc_src, imem_rdata, instr_ready,
      output imem_req, imem_addr, instr_valid, instr_if, cur_pc_if, occupancy
   );

   modport slave (
      output branch_target, pc_src, imem_rdata, instr_ready,
      input  imem_req, imem_addr, instr_valid, instr_if, cur_pc_if, occupancy
   );
endinterface

// File: rtl/fetch_queue.sv
// Instruction fetch queue: issues sequential imem reads, buffers {pc, instr} for decode,
// handles redirects. Optional same-cycle response bypass with FETCH_QUEUE_BYPASS_EN.
module fetch_queue #(
   parameter int              WORD      = 64,
   parameter int              INSTR_LEN = 32,
   parameter int              DEPTH     = 4,
   parameter logic [WORD-1:0] RESET_PC  = '0
) (
   input logic           clk,
   input logic           reset,
   fetch_queue_if.master bus
);
   localparam int              PTR_W   = $clog2(DEPTH);
   localparam int              OCC_W   = $clog2(DEPTH + 1);
   localparam logic [OCC_W:0]  DEPTH_L = (OCC_W + 1)'(DEPTH);

   logic [WORD-1:0]      fetch_pc;
   logic [WORD-1:0]      req_pc;
   logic                 inflight;
   logic [PTR_W-1:0]     rd_ptr;
   logic [PTR_W-1:0]     wr_ptr;
   logic [OCC_W-1:0]     count;
   logic [INSTR_LEN-1:0] mem_instr [DEPTH];
   logic [WORD-1:0]      mem_pc    [DEPTH];

   logic                 q_empty;
   logic [OCC_W:0]       pending;
   logic                 issue;
   logic                 bypass;
   logic                 head_valid;
   logic                 push;
   logic                 pop;

   always_comb begin
      q_empty = (count == '0);
      // Queue slots already spoken for, including the response still on its way.
      pending = {1'b0, count} + {{OCC_W{1'b0}}, inflight};
      issue   = reset && !bus.pc_src && (pending < DEPTH_L);
`ifdef FETCH_QUEUE_BYPASS_EN
      bypass  = inflight && q_empty && !bus.pc_src;
`else
      bypass  = 1'b0;
`endif
      head_valid = reset && !bus.pc_src && (!q_empty || bypass);
      pop        = head_valid && bus.instr_ready && !q_empty;
      // A bypassed response taken by decode this cycle never lands in the queue.
      push       = inflight && !bus.pc_src && !(bypass && bus.instr_ready);
   end

   assign bus.imem_req    = issue;
   assign bus.imem_addr   = fetch_pc;
   assign bus.instr_valid = head_valid;
   assign bus.instr_if    = bypass ? bus.imem_rdata : mem_instr[rd_ptr];
   assign bus.cur_pc_if   = bypass ? req_pc : mem_pc[rd_ptr];
   assign bus.occupancy   = count;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fetch_pc <= RESET_PC;
         req_pc   <= '0;
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else if (bus.pc_src) begin
         // Redirect flushes everything; the pending response is dropped by clearing inflight.
         fetch_pc <= {bus.branch_target[WORD-1:2], 2'b00};
         inflight <= 1'b0;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
      end else begin
         inflight <= issue;
         if (issue) begin
            req_pc   <= fetch_pc;
            fetch_pc <= fetch_pc + WORD'(4);
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage needs no reset: entries are only observed through count.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_instr[wr_ptr] <= bus.imem_rdata;
         mem_pc[wr_ptr]    <= req_pc;
      end
   end
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: DEPTH 2/4/8 instances share stimulus; a queue-level model
// predicts every output each cycle. Honours FETCH_QUEUE_BYPASS_EN.
module tb_fetch_queue;
  localparam int WORD = 64;
  localparam int IL   = 32;
`ifdef FETCH_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset = 1'b0;
  logic            pc_src = 1'b0;
  logic [WORD-1:0] branch_target = '0;
  logic            instr_ready = 1'b1;

  fetch_queue_if #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(2)) bus2 ();
  fetch_queue_if #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(4)) bus4 ();
  fetch_queue_if #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(8)) bus8 ();

  fetch_queue #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(2)) u_dut2 (.clk(clk), .reset(reset), .bus(bus2.master));
  fetch_queue #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(4)) u_dut4 (.clk(clk), .reset(reset), .bus(bus4.master));
  fetch_queue #(.WORD(WORD), .INSTR_LEN(IL), .DEPTH(8)) u_dut8 (.clk(clk), .reset(reset), .bus(bus8.master));

  assign bus2.pc_src = pc_src;  assign bus2.branch_target = branch_target;  assign bus2.instr_ready = instr_ready;
  assign bus4.pc_src = pc_src;  assign bus4.branch_target = branch_target;  assign bus4.instr_ready = instr_ready;
  assign bus8.pc_src = pc_src;  assign bus8.branch_target = branch_target;  assign bus8.instr_ready = instr_ready;

  logic            o_req   [3];
  logic [WORD-1:0] o_addr  [3];
  logic            o_valid [3];
  logic [IL-1:0]   o_instr [3];
  logic [WORD-1:0] o_pc    [3];
  logic [7:0]      o_occ   [3];

  assign o_req[0] = bus2.imem_req;  assign o_addr[0] = bus2.imem_addr;  assign o_valid[0] = bus2.instr_valid;
  assign o_instr[0] = bus2.instr_if;  assign o_pc[0] = bus2.cur_pc_if;  assign o_occ[0] = 8'(bus2.occupancy);
  assign o_req[1] = bus4.imem_req;  assign o_addr[1] = bus4.imem_addr;  assign o_valid[1] = bus4.instr_valid;
  assign o_instr[1] = bus4.instr_if;  assign o_pc[1] = bus4.cur_pc_if;  assign o_occ[1] = 8'(bus4.occupancy);
  assign o_req[2] = bus8.imem_req;  assign o_addr[2] = bus8.imem_addr;  assign o_valid[2] = bus8.instr_valid;
  assign o_instr[2] = bus8.instr_if;  assign o_pc[2] = bus8.cur_pc_if;  assign o_occ[2] = 8'(bus8.occupancy);

  // instruction memory: word at address a holds a>>2, returned one cycle after the read
  logic [IL-1:0] rdata [3];
  always @(posedge clk) begin
    rdata[0] <= o_addr[0][33:2];
    rdata[1] <= o_addr[1][33:2];
    rdata[2] <= o_addr[2][33:2];
  end
  assign bus2.imem_rdata = rdata[0];
  assign bus4.imem_rdata = rdata[1];
  assign bus8.imem_rdata = rdata[2];

  // scoreboard / reference model: queue of expected {pc, instr} entries per instance
  logic [WORD+IL-1:0] exp_q [3][$];
  logic [WORD-1:0]    m_pc     [3];
  logic               m_inf    [3];
  logic [WORD-1:0]    m_inf_pc [3];

  int n_checks = 0;
  int n_errors = 0;

  // DEPTH=4 instance snapshot, for directed checks against fixed values
  logic            s_req;
  logic [WORD-1:0] s_addr;
  logic            s_valid;
  logic [WORD-1:0] s_pc;
  logic [IL-1:0]   s_instr;
  logic [7:0]      s_occ;

  function automatic int dep(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 4 : 8);
  endfunction

  function automatic logic [WORD+IL-1:0] entry(input logic [WORD-1:0] pc);
    return {pc, pc[33:2]};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      m_pc[k]     = '0;
      m_inf[k]    = 1'b0;
      m_inf_pc[k] = '0;
    end
  endtask

  // driver: one clock cycle of stimulus, checked against the model before the edge
  task automatic step(input logic r, input logic ps, input logic [WORD-1:0] bt, input logic rdy);
    logic e_req   [3];
    logic e_valid [3];
    int   sz      [3];
    logic [WORD+IL-1:0] head;
    logic consumed;
    @(negedge clk);
    reset = r; pc_src = ps; branch_target = bt; instr_ready = rdy;
    if (!r) model_reset();
    #1;
    for (int k = 0; k < 3; k++) begin
      sz[k]      = exp_q[k].size();
      e_req[k]   = r && !ps && ((sz[k] + int'(m_inf[k])) < dep(k));
      e_valid[k] = r && !ps && ((sz[k] != 0) || (BYP && m_inf[k]));
      check($sformatf("req_d%0d", dep(k)),   o_req[k],   e_req[k]);
      check($sformatf("addr_d%0d", dep(k)),  o_addr[k],  m_pc[k]);
      check($sformatf("valid_d%0d", dep(k)), o_valid[k], e_valid[k]);
      check($sformatf("occ_d%0d", dep(k)),   o_occ[k],   sz[k]);
      if (e_valid[k]) begin
        head = (sz[k] != 0) ? exp_q[k][0] : entry(m_inf_pc[k]);
        check($sformatf("head_d%0d", dep(k)), {o_pc[k], o_instr[k]}, head);
      end
    end
    s_req = o_req[1]; s_addr = o_addr[1]; s_valid = o_valid[1];
    s_pc = o_pc[1]; s_instr = o_instr[1]; s_occ = o_occ[1];
    @(posedge clk);
    if (r) begin
      for (int k = 0; k < 3; k++) begin
        if (ps) begin
          exp_q[k].delete();
          m_inf[k] = 1'b0;
          m_pc[k]  = {bt[WORD-1:2], 2'b00};
        end else begin
          consumed = 1'b0;
          if (e_valid[k] && rdy) begin
            if (sz[k] != 0) void'(exp_q[k].pop_front());
            else consumed = 1'b1;
          end
          if (m_inf[k] && !consumed) exp_q[k].push_back(entry(m_inf_pc[k]));
          m_inf[k] = e_req[k];
          if (e_req[k]) begin
            m_inf_pc[k] = m_pc[k];
            m_pc[k]     = m_pc[k] + 64'd4;
          end
        end
      end
    end
  endtask

  initial begin
    model_reset();
    repeat (3) step(1'b0, 1'b0, '0, 1'b1);
    check("rst_addr", s_addr, 64'h0);
    check("rst_req", s_req, 1'b0);
    check("rst_occ", s_occ, 8'd0);

    // streaming from reset, decode always ready
    step(1'b1, 1'b0, '0, 1'b1);
    check("s1_addr", s_addr, 64'h0);
    check("s1_req", s_req, 1'b1);
    check("s1_valid", s_valid, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("s2_addr", s_addr, 64'h4);
    check("s2_valid", s_valid, BYP);
    step(1'b1, 1'b0, '0, 1'b1);
    check("s3_addr", s_addr, 64'h8);
    check("s3_valid", s_valid, 1'b1);
    check("s3_pc", s_pc, BYP ? 64'h4 : 64'h0);
    check("s3_instr", s_instr, BYP ? 32'h1 : 32'h0);
    repeat (5) step(1'b1, 1'b0, '0, 1'b1);

    // decode stalled: queue saturates, fetch stops at 16
    step(1'b0, 1'b0, '0, 1'b0);
    repeat (8) step(1'b1, 1'b0, '0, 1'b0);
    check("sat_occ", s_occ, 8'd4);
    check("sat_req", s_req, 1'b0);
    check("sat_addr", s_addr, 64'h10);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 1'b1);
      check("drain_pc", s_pc, 64'(i * 4));
      check("drain_instr", s_instr, 32'(i));
    end

    // redirect with three queued entries and one response in flight
    step(1'b0, 1'b0, '0, 1'b0);
    repeat (5) step(1'b1, 1'b0, '0, 1'b0);
    check("pre_redir_occ", s_occ, 8'd3);
    step(1'b1, 1'b1, 64'h103, 1'b0);
    check("redir_valid", s_valid, 1'b0);
    check("redir_req", s_req, 1'b0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("post_redir_occ", s_occ, 8'd0);
    check("post_redir_addr", s_addr, 64'h100);
    check("post_redir_req", s_req, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("redir_head_pc", s_pc, BYP ? 64'h104 : 64'h100);

    // PC wrap at the top of the address space
    step(1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_addr0", s_addr, 64'hFFFF_FFFF_FFFF_FFFC);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_addr1", s_addr, 64'h0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("wrap_pc", s_pc, BYP ? 64'h0 : 64'hFFFF_FFFF_FFFF_FFFC);
    check("wrap_instr", s_instr, BYP ? 32'h0 : 32'hFFFF_FFFF);
    repeat (4) step(1'b1, 1'b0, '0, 1'b1);

    // reset in the middle of a stream
    step(1'b1, 1'b1, 64'h200, 1'b0);
    repeat (5) step(1'b1, 1'b0, '0, 1'b0);
    check("pre_rst_occ", s_occ, 8'd3);
    step(1'b0, 1'b0, '0, 1'b1);
    check("mid_rst_occ", s_occ, 8'd0);
    check("mid_rst_req", s_req, 1'b0);
    check("mid_rst_valid", s_valid, 1'b0);
    check("mid_rst_addr", s_addr, 64'h0);
    step(1'b1, 1'b0, '0, 1'b1);
    check("rel_addr", s_addr, 64'h0);
    check("rel_valid", s_valid, 1'b0);

    // randomized traffic: stalls, redirects and occasional reset
    for (int c = 0; c < 800; c++) begin
      logic            r, ps, rdy;
      logic [WORD-1:0] bt;
      r   = ($urandom_range(0, 199) != 0);
      ps  = ($urandom_range(0, 24) == 0);
      bt  = {$urandom, $urandom};
      rdy = ((c / 50) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      step(r, ps, bt, rdy);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
